fpu_mul_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `fpuMul16` FP16 multiply unit among `NREQ` requesters. It accepts one operand pair at a time and drives the unit's `start` pulse. It waits for the unit's `done`, returns the result and condition codes to the winning requester, then clears the unit with a one-cycle local reset. The clear is required because the unit's `done` stays high until the unit is reset. The block sits between the core-side request ports and the single multiply coprocessor instance.

---
 rtl/fpu_mul_arbiter.sv | 140 ++++++++++++++
 tb/tb_fpu_mul_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_mul_arbiter.sv
// Round-robin arbiter that time-shares one FP16 multiply unit among NREQ requesters:
// accept, start, wait for done (or time out), respond, then clear the unit's sticky done.
module fpu_mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NREQ-1:0]           reqValid,
  input  logic [16*NREQ-1:0]        reqOp1,
  input  logic [16*NREQ-1:0]        reqOp2,
  output logic [NREQ-1:0]           reqReady,
  output logic [NREQ-1:0]           respValid,
  input  logic [NREQ-1:0]           respReady,
  output logic [15:0]               respResult,
  output logic [3:0]                respCondCodes,
  output logic                      respErr,
  output logic                      busy,
  output logic [$clog2(NREQ)-1:0]   grantId,
  output logic [15:0]               unitIn1,
  output logic [15:0]               unitIn2,
  output logic                      unitStart,
  output logic                      unitReset,
  input  logic                      unitDone,
  input  logic [15:0]               unitOut,
  input  logic [3:0]                unitCondCodes
);

  typedef logic [15:0] fp16_t;
  typedef enum logic [2:0] {IDLE, ISSUE, BUSY, RESP, CLEAR} state_t;

  localparam int IW  = $clog2(NREQ);
  localparam int IW1 = IW + 1;
  localparam int CW  = $clog2(TIMEOUT) + 1;

  state_t          state;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   grant;
  fp16_t           op_reg1;
  fp16_t           op_reg2;
  fp16_t           result_reg;
  logic [3:0]      codes_reg;
  logic            err_reg;
  logic [CW-1:0]   tmo_cnt;
  logic [CW-1:0]   tmo_next;

  fp16_t           op1_arr [NREQ];
  fp16_t           op2_arr [NREQ];
  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic [IW1-1:0]  cand;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign op1_arr[gi] = reqOp1[16*gi +: 16];
      assign op2_arr[gi] = reqOp2[16*gi +: 16];
    end
  endgenerate

  // Scan from the farthest candidate to the nearest so the nearest set index after last_grant wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = {1'b0, last_grant} + IW1'(k);
      if (cand >= IW1'(NREQ)) cand = cand - IW1'(NREQ);
      if (reqValid[cand[IW-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[IW-1:0];
      end
    end
  end

  assign reqReady      = (state == IDLE && pick_valid) ? (NREQ'(1) << pick_idx) : '0;
  assign respValid     = (state == RESP) ? (NREQ'(1) << grant) : '0;
  assign unitStart     = (state == ISSUE);
  assign busy          = (state != IDLE);
  assign unitReset     = reset | (state == CLEAR);
  assign unitIn1       = op_reg1;
  assign unitIn2       = op_reg2;
  assign grantId       = grant;
  assign respResult    = result_reg;
  assign respCondCodes = codes_reg;
  assign respErr       = err_reg;
  assign tmo_next      = tmo_cnt + 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= IW'(NREQ - 1);
      grant      <= '0;
      op_reg1    <= '0;
      op_reg2    <= '0;
      result_reg <= '0;
      codes_reg  <= '0;
      err_reg    <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant   <= pick_idx;
            op_reg1 <= op1_arr[pick_idx];
            op_reg2 <= op2_arr[pick_idx];
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          tmo_cnt <= '0;
          state   <= BUSY;
        end
        BUSY: begin
          tmo_cnt <= tmo_next;
          // A done arriving in the expiry cycle still counts as a good result.
          if (unitDone) begin
            result_reg <= unitOut;
            codes_reg  <= unitCondCodes;
            err_reg    <= 1'b0;
            state      <= RESP;
          end else if (tmo_next == CW'(TIMEOUT - 1)) begin
            result_reg <= '0;
            codes_reg  <= '0;
            err_reg    <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (respReady[grant]) begin
            last_grant <= grant;
            state      <= CLEAR;
          end
        end
        CLEAR: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Randomized and directed bench for fpu_mul_arbiter against a cycle-timestamp reference model
// and a behavioural FP16 multiply unit with configurable latency.
module tb_fpu_mul_arbiter;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;
  localparam int IW      = 2;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      reqValid, reqReady, respValid, respReady;
  logic [16*NREQ-1:0]   reqOp1, reqOp2;
  logic [15:0]          respResult, unitIn1, unitIn2, unitOut;
  logic [3:0]           respCondCodes, unitCondCodes;
  logic                 respErr, busy, unitStart, unitReset, unitDone;
  logic [IW-1:0]        grantId;

  fpu_mul_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .reqValid(reqValid), .reqOp1(reqOp1), .reqOp2(reqOp2),
    .reqReady(reqReady), .respValid(respValid), .respReady(respReady),
    .respResult(respResult), .respCondCodes(respCondCodes), .respErr(respErr),
    .busy(busy), .grantId(grantId), .unitIn1(unitIn1), .unitIn2(unitIn2),
    .unitStart(unitStart), .unitReset(unitReset), .unitDone(unitDone),
    .unitOut(unitOut), .unitCondCodes(unitCondCodes)
  );

  always #5 clock = ~clock;

  // Normal-range FP16 multiply with truncation; operands are kept in range to avoid over/underflow.
  function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
    logic [21:0] p;
    int          e;
    logic [9:0]  m;
    p = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
    e = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (p[21]) begin m = p[20:11]; e = e + 1; end
    else m = p[19:10];
    return {a[15] ^ b[15], 5'(e), m};
  endfunction

  function automatic logic [15:0] rand_op();
    logic [15:0] r;
    r[15]    = 1'($urandom);
    r[14:10] = 5'($urandom_range(22, 8));
    r[9:0]   = 10'($urandom);
    return r;
  endfunction

  // Multiply unit model: start latches operands, done rises lat cycles later and sticks until reset.
  int   lat = 6;
  bit   never_done = 1'b0;
  int   u_cnt;
  bit   u_act;
  logic [15:0] u_a, u_b;
  always @(posedge clock) begin
    if (unitReset) begin
      unitDone <= 1'b0; u_act <= 1'b0; u_cnt <= 0; unitOut <= '0; unitCondCodes <= '0;
    end else if (unitStart) begin
      u_act <= 1'b1; u_cnt <= lat; u_a <= unitIn1; u_b <= unitIn2;
    end else if (u_act && !unitDone && !never_done) begin
      if (u_cnt <= 1) begin
        unitDone <= 1'b1; unitOut <= fp16_mul(u_a, u_b); unitCondCodes <= 4'($urandom);
      end else u_cnt <= u_cnt - 1;
    end
  end

  int checks = 0, errors = 0, cyc = 0;
  bit [NREQ-1:0] pending;
  logic [15:0] op1_v [NREQ];
  logic [15:0] op2_v [NREQ];
  bit continuous = 1'b0, random_mode = 1'b0;
  int ready_delay = 0, resp_seen = 0, resp_count = 0;
  bit m_active;
  int m_last, m_grant, m_issue, m_resp, m_clear, last_accept, obs_start;
  logic [15:0] m_a, m_b, m_res;
  logic [3:0] m_cc;
  bit m_err;
  int grant_log[$];
  logic [15:0] last_result;
  bit last_err;
  int last_grant_seen, last_latency, last_hold;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  task automatic check_reset_vals(input string tag);
    check_value({tag, "_reqReady"}, 32'(reqReady), 0);
    check_value({tag, "_respValid"}, 32'(respValid), 0);
    check_value({tag, "_respResult"}, 32'(respResult), 0);
    check_value({tag, "_codes"}, 32'(respCondCodes), 0);
    check_value({tag, "_respErr"}, 32'(respErr), 0);
    check_value({tag, "_busy"}, 32'(busy), 0);
    check_value({tag, "_grantId"}, 32'(grantId), 0);
    check_value({tag, "_unitStart"}, 32'(unitStart), 0);
    check_value({tag, "_unitIn1"}, 32'(unitIn1), 0);
    check_value({tag, "_unitIn2"}, 32'(unitIn2), 0);
    check_value({tag, "_unitReset"}, 32'(unitReset), 1);
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_last = NREQ - 1; m_grant = 0; m_issue = -1; m_resp = -1;
    m_clear = -1; last_accept = -1; obs_start = -1; resp_seen = 0; pending = '0;
  endtask

  task automatic drive_inputs();
    logic [NREQ-1:0] rr;
    if (continuous) pending = '1;
    if (random_mode)
      for (int i = 0; i < NREQ; i++) begin
        if (!pending[i] && $urandom_range(2) == 0) begin
          pending[i] = 1'b1; op1_v[i] = rand_op(); op2_v[i] = rand_op();
        end else if (pending[i] && $urandom_range(15) == 0) pending[i] = 1'b0;
      end
    reqValid = pending;
    for (int i = 0; i < NREQ; i++) begin
      reqOp1[16*i +: 16] = op1_v[i];
      reqOp2[16*i +: 16] = op2_v[i];
    end
    if (respValid != '0) begin
      rr = (resp_seen >= ready_delay) ? respValid : '0;
      resp_seen++;
    end else begin
      rr = '0; resp_seen = 0;
    end
    respReady = rr | (~respValid & NREQ'($urandom));
  endtask

  task automatic model_step();
    int c, w;
    bit in_resp;
    logic [NREQ-1:0] exp_ready, exp_rv;
    c = cyc;
    w = m_active ? -1 : rr_pick(reqValid, m_last);
    exp_ready = (w >= 0) ? (NREQ'(1) << w) : '0;
    in_resp = m_active && m_resp >= 0 && c >= m_resp && m_clear < 0;
    exp_rv = in_resp ? (NREQ'(1) << m_grant) : '0;
    check_value("reqReady", 32'(reqReady), 32'(exp_ready));
    check_value("respValid", 32'(respValid), 32'(exp_rv));
    check_value("busy", 32'(busy), 32'(m_active));
    check_value("unitStart", 32'(unitStart), 32'(m_active && c == m_issue));
    check_value("unitReset", 32'(unitReset), 32'(m_active && c == m_clear));
    check_value("grantId", 32'(grantId), 32'(m_grant));
    if (m_active) begin
      check_value("unitIn1", 32'(unitIn1), 32'(m_a));
      check_value("unitIn2", 32'(unitIn2), 32'(m_b));
      if (respValid != '0 && obs_start < 0) obs_start = c;
    end
    if (in_resp) begin
      check_value("respResult", 32'(respResult), 32'(m_res));
      check_value("respCondCodes", 32'(respCondCodes), 32'(m_cc));
      check_value("respErr", 32'(respErr), 32'(m_err));
    end
    if (w >= 0) begin
      if (last_accept >= 0) check_value("accept_gap_ge5", 32'(c - last_accept >= 5), 1);
      last_accept = c;
      m_active = 1'b1; m_grant = w; m_issue = c + 1; m_resp = -1; m_clear = -1;
      m_a = op1_v[w]; m_b = op2_v[w]; obs_start = -1;
      if (continuous) grant_log.push_back(w);
      else pending[w] = 1'b0;
      if (random_mode) begin lat = $urandom_range(1, 12); ready_delay = $urandom_range(0, 3); end
    end else if (m_active && m_resp < 0 && c > m_issue) begin
      if (unitDone) begin
        m_resp = c + 1; m_err = 1'b0; m_res = fp16_mul(m_a, m_b); m_cc = unitCondCodes;
      end else if (c == m_issue + TIMEOUT - 1) begin
        m_resp = c + 1; m_err = 1'b1; m_res = '0; m_cc = '0;
      end
    end else if (in_resp && respReady[m_grant]) begin
      m_last = m_grant; m_clear = c + 1; resp_count++;
      last_result = respResult; last_err = respErr; last_grant_seen = int'(grantId);
      last_latency = obs_start - m_issue; last_hold = c - obs_start;
      $display("TXN req=%0d a=%h b=%h result=%h cc=%h err=%0d resp_after_issue=%0d",
               m_grant, m_a, m_b, respResult, respCondCodes, respErr, last_latency);
    end else if (m_active && c == m_clear) begin
      m_active = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clock);
    cyc++;
    drive_inputs();
    #2;
    if (!reset) model_step();
  endtask

  task automatic run_until(input int n, input int budget);
    int target, i;
    target = resp_count + n; i = 0;
    while (resp_count < target && i < budget) begin tick(); i++; end
    if (resp_count < target) check_value("wait_budget_responses", 32'(resp_count), 32'(target));
  endtask

  task automatic arm(input int i, input logic [15:0] a, input logic [15:0] b);
    op1_v[i] = a; op2_v[i] = b; pending[i] = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order [5];
    int i;
    exp_order = '{0, 1, 2, 3, 0};
    reset = 1'b1; reqValid = '0; respReady = '0; reqOp1 = '0; reqOp2 = '0;
    for (int k = 0; k < NREQ; k++) begin op1_v[k] = '0; op2_v[k] = '0; end
    model_reset();
    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    check_reset_vals("por");
    reset = 1'b0;

    // Requester 0 (1.0 x 2.0) wins first from reset, then requester 1.
    lat = 6; ready_delay = 0;
    arm(0, 16'h3C00, 16'h4000);
    arm(1, 16'h3C00, 16'h3C00);
    run_until(1, 100);
    check_value("t1_result", 32'(last_result), 32'h4000);
    check_value("t1_err", 32'(last_err), 0);
    check_value("t1_grant", 32'(last_grant_seen), 0);
    run_until(1, 100);
    check_value("t1b_grant", 32'(last_grant_seen), 1);

    // Requester 2: 2.0 x 3.0.
    lat = 4;
    arm(2, 16'h4000, 16'h4200);
    run_until(1, 100);
    check_value("t2_result", 32'(last_result), 32'h4600);
    check_value("t2_grant", 32'(last_grant_seen), 2);

    // Reset in the middle of BUSY; the in-flight op vanishes.
    lat = 40;
    arm(1, rand_op(), rand_op());
    i = 0;
    while (!(m_active && m_resp < 0 && cyc >= m_issue + 3) && i < 50) begin tick(); i++; end
    check_value("reached_busy", 32'(m_active && cyc >= m_issue + 3), 1);
    #1 reset = 1'b1; reqValid = '0;
    #1 check_reset_vals("mid_busy");
    model_reset();
    repeat (2) begin @(posedge clock); #1 check_reset_vals("in_reset"); end
    @(negedge clock); #1 reset = 1'b0;
    lat = 5;
    arm(3, rand_op(), rand_op());
    run_until(1, 100);
    check_value("t6_grant", 32'(last_grant_seen), 3);

    // All requesters valid continuously.
    grant_log.delete();
    continuous = 1'b1; lat = 2; ready_delay = 0;
    run_until(5, 300);
    continuous = 1'b0; pending = '0;
    check_value("rr_log_size", 32'(grant_log.size()), 5);
    if (grant_log.size() >= 5)
      for (int k = 0; k < 5; k++)
        check_value($sformatf("rr_order%0d", k), 32'(grant_log[k]), 32'(exp_order[k]));

    // Response held for 10 cycles while others wait.
    lat = 3; ready_delay = 10;
    for (int k = 0; k < NREQ; k++) arm(k, rand_op(), rand_op());
    run_until(1, 100);
    check_value("hold_cycles", 32'(last_hold), 10);
    ready_delay = 0;
    run_until(3, 200);

    // Timeout, then a normal op.
    never_done = 1'b1;
    arm(1, rand_op(), rand_op());
    run_until(1, 200);
    check_value("tmo_err", 32'(last_err), 1);
    check_value("tmo_result", 32'(last_result), 0);
    check_value("tmo_latency", 32'(last_latency), TIMEOUT);
    never_done = 1'b0; lat = 5;
    arm(2, 16'h3C00, 16'h3C00);
    run_until(1, 100);
    check_value("post_tmo_err", 32'(last_err), 0);
    check_value("post_tmo_result", 32'(last_result), 32'h3C00);

    // Done in the expiry cycle wins; one cycle later it loses.
    lat = TIMEOUT - 2;
    arm(0, rand_op(), rand_op());
    run_until(1, 200);
    check_value("edge_done_err", 32'(last_err), 0);
    check_value("edge_done_latency", 32'(last_latency), TIMEOUT);
    lat = TIMEOUT - 1;
    arm(3, rand_op(), rand_op());
    run_until(1, 200);
    check_value("edge_late_err", 32'(last_err), 1);
    check_value("edge_late_latency", 32'(last_latency), TIMEOUT);

    // Randomized traffic with withdrawals and random response backpressure.
    random_mode = 1'b1;
    run_until(40, 4000);
    random_mode = 1'b0; pending = '0;
    i = 0;
    while (m_active && i < 200) begin tick(); i++; end
    check_value("drained", 32'(m_active), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
